spi_storage_responder: RTL and testbench

Synthesizable SPI flash responder that models the external storage device on the far end of the storage controller's `external_storage_spi_*` bus. It decodes a subset of standard serial-flash commands (READ 0x03, PAGE PROGRAM 0x02, READ STATUS 0x05, WREN 0x06, WRDI 0x04) against an internal byte array. It is used as the storage target in system simulation and FPGA bring-up, and it lets the programming SPI path be exercised end to end.

---
 rtl/spi_storage_responder_if.sv | 9 +
 rtl/spi_storage_responder.sv | 127 ++++++++++++
 tb/tb_spi_storage_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_storage_responder_if.sv
// spi_storage_responder_if: SPI bus between a flash host and the storage responder.
interface spi_storage_responder_if;
   logic spi_cs_n;
   logic spi_sck;
   logic spi_mosi;
   logic spi_miso;
   modport master (output spi_cs_n, spi_sck, spi_mosi, input spi_miso);
   modport slave (input spi_cs_n, spi_sck, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_storage_responder.sv
// spi_storage_responder: serial-flash model (READ/PP/RDSR/WREN/WRDI) over an internal byte array.
// Define SPI_RESP_WEL_EN to make WEL gate PAGE PROGRAM and auto-clear after it.
module spi_storage_responder #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   spi_storage_responder_if.slave   spi,
   input  logic [$clog2(DEPTH)-1:0] bd_addr,
   output logic [7:0]               bd_data,
   output logic                     wel
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE} state_t;
   state_t      state;
   logic [1:0]  cs_s, sck_s, mosi_s, acnt;
   logic        sck_d, rise, fall, mosi_q, cs_q, rd, miso, done, we;
   logic [2:0]  cnt;
   logic [7:0]  rx, tx, nxt;
   logic [AW-1:0] addr, addr_inc, addr_nxt;
   logic [7:0]  mem [DEPTH];
`ifdef SPI_RESP_WEL_EN
   logic        wr_ok, prog;
`endif
   assign nxt      = {rx[6:0], mosi_q};
   assign addr_nxt = AW'({addr, nxt});
   assign addr_inc = addr + AW'(1);
   assign done     = rise && !cs_q && state != IDLE && cnt == 3'd7;
`ifdef SPI_RESP_WEL_EN
   assign we = done && state == WDATA && wr_ok;
`else
   assign we = done && state == WDATA;
`endif
   assign bd_data  = mem[bd_addr];
   assign spi.spi_miso = miso;
   // Array has no reset so its contents survive a reset mid-transaction
   always_ff @(posedge clk)
      if (we) mem[addr] <= nxt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_s   <= 2'b11;
         sck_s  <= '0;
         mosi_s <= '0;
         sck_d  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         mosi_q <= 1'b0;
         cs_q   <= 1'b1;
         state  <= IDLE;
         cnt    <= '0;
         acnt   <= '0;
         rx     <= '0;
         tx     <= '0;
         addr   <= '0;
         rd     <= 1'b0;
         miso   <= 1'b0;
         wel    <= 1'b0;
`ifdef SPI_RESP_WEL_EN
         wr_ok  <= 1'b0;
         prog   <= 1'b0;
`endif
      end else begin
         cs_s   <= {cs_s[0], spi.spi_cs_n};
         sck_s  <= {sck_s[0], spi.spi_sck};
         mosi_s <= {mosi_s[0], spi.spi_mosi};
         sck_d  <= sck_s[1];
         rise   <= sck_s[1] & ~sck_d;
         fall   <= ~sck_s[1] & sck_d;
         mosi_q <= mosi_s[1];
         cs_q   <= cs_s[1];
         if (cs_q) begin
            state <= IDLE;
            cnt   <= '0;
            rx    <= '0;
            miso  <= 1'b0;
`ifdef SPI_RESP_WEL_EN
            if (prog) wel <= 1'b0;
            prog  <= 1'b0;
`endif
         end else begin
            if (state == IDLE) state <= CMD;
            if (rise && state != IDLE) begin
               rx  <= nxt;
               cnt <= cnt + 3'd1;
            end
            if (done)
               case (state)
                  CMD: begin
                     acnt <= '0;
                     case (nxt)
                        8'h03: begin state <= ADDR; rd <= 1'b1; end
                        8'h02: begin
                           state <= ADDR;
                           rd    <= 1'b0;
`ifdef SPI_RESP_WEL_EN
                           wr_ok <= wel;
                           prog  <= 1'b1;
`endif
                        end
                        8'h05: begin state <= STATUS; tx <= {6'b0, wel, 1'b0}; end
                        8'h06: begin state <= IGNORE; wel <= 1'b1; end
                        8'h04: begin state <= IGNORE; wel <= 1'b0; end
                        default: state <= IGNORE;
                     endcase
                  end
                  ADDR: begin
                     addr <= addr_nxt;
                     acnt <= acnt + 2'd1;
                     if (acnt == 2'(ADDR_W / 8 - 1)) begin
                        state <= rd ? RDATA : WDATA;
                        tx    <= mem[addr_nxt];
                     end
                  end
                  RDATA: begin addr <= addr_inc; tx <= mem[addr_inc]; end
                  WDATA: addr <= addr_inc;
                  STATUS: tx <= {6'b0, wel, 1'b0};
                  default: ;
               endcase
            if (fall) begin
               miso <= (state == RDATA || state == STATUS) && tx[7];
               tx   <= {tx[6:0], 1'b0};
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_storage_responder.sv
// tb_spi_storage_responder: directed SPI host transactions with hand-computed expected bytes.
module tb_spi_storage_responder;
   logic clk = 1'b0, rst = 1'b0;
   logic [9:0] bd_addr = '0;
   logic [7:0] bd_data, rx;
   logic wel;
   int checks = 0, errors = 0;
   spi_storage_responder_if sif();
   spi_storage_responder #(.DEPTH(1024), .ADDR_W(24)) dut (
      .clk(clk), .rst(rst), .spi(sif), .bd_addr(bd_addr), .bd_data(bd_data), .wel(wel)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic shift(input logic [7:0] o, input int n, output logic [7:0] i);
      i = '0;
      for (int b = 7; b > 7 - n; b--) begin
         sif.spi_mosi = o[b];
         wait_clk(6);
         i[b] = sif.spi_miso;
         sif.spi_sck = 1'b1;
         wait_clk(6);
         sif.spi_sck = 1'b0;
      end
   endtask
   task automatic xb(input logic [7:0] o);
      shift(o, 8, rx);
   endtask
   task automatic start();
      sif.spi_cs_n = 1'b0;
      wait_clk(6);
   endtask
   task automatic stop();
      wait_clk(6);
      sif.spi_cs_n = 1'b1;
      wait_clk(8);
   endtask
   task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
      xb(op);
      xb(a[23:16]);
      xb(a[15:8]);
      xb(a[7:0]);
   endtask
   task automatic single(input logic [7:0] op);
      start();
      xb(op);
      stop();
   endtask
   task automatic program2(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
      start();
      cmd_addr(8'h02, a);
      xb(d0);
      xb(d1);
      stop();
   endtask
   task automatic read2(input string tag, input logic [23:0] a, input logic [7:0] e0, input logic [7:0] e1);
      start();
      cmd_addr(8'h03, a);
      xb(8'h00);
      check({tag, "_b0"}, rx, e0);
      xb(8'h00);
      check({tag, "_b1"}, rx, e1);
      stop();
   endtask
   task automatic chk_mem(input string tag, input logic [9:0] a, input logic [7:0] e);
      bd_addr = a;
      #1;
      check(tag, bd_data, e);
   endtask
   initial begin
      sif.spi_cs_n = 1'b1;
      sif.spi_sck  = 1'b0;
      sif.spi_mosi = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_clk(3);
         sif.spi_sck = ~sif.spi_sck;
      end
      check("rst_miso", sif.spi_miso, 1'b0);
      check("rst_wel", wel, 1'b0);
      rst = 1'b1;
      wait_clk(4);
      single(8'h06);
      check("wren_wel", wel, 1'b1);
      start();
      xb(8'h05);
      xb(8'h00);
      check("rdsr_wel_b0", rx, 8'h02);
      xb(8'h00);
      check("rdsr_wel_b1", rx, 8'h02);
      stop();
      program2(24'h000010, 8'hA5, 8'h3C);
      chk_mem("pp_10", 10'h010, 8'hA5);
      chk_mem("pp_11", 10'h011, 8'h3C);
`ifdef SPI_RESP_WEL_EN
      check("pp_wel_clr", wel, 1'b0);
      start();
      xb(8'h05);
      xb(8'h00);
      check("rdsr_after_pp", rx, 8'h00);
      stop();
`endif
      read2("rd_10", 24'h000010, 8'hA5, 8'h3C);
      single(8'h06);
      program2(24'h0003FF, 8'h11, 8'h22);
      chk_mem("wrap_3ff", 10'h3FF, 8'h11);
      chk_mem("wrap_000", 10'h000, 8'h22);
      read2("rd_wrap", 24'h0003FF, 8'h11, 8'h22);
      single(8'h06);
      program2(24'h000030, 8'h00, 8'h01);
      single(8'h06);
      start();
      cmd_addr(8'h02, 24'h000030);
      xb(8'hC3);
      shift(8'hFF, 5, rx);
      stop();
      chk_mem("part_30", 10'h030, 8'hC3);
      chk_mem("part_31", 10'h031, 8'h01);
      read2("rd_after_part", 24'h000030, 8'hC3, 8'h01);
      start();
      xb(8'h9F);
      xb(8'h00);
      check("jedec_b0", rx, 8'h00);
      xb(8'h00);
      check("jedec_b1", rx, 8'h00);
      stop();
      single(8'h04);
      check("wrdi_wel", wel, 1'b0);
      start();
      xb(8'h05);
      xb(8'h00);
      check("rdsr_wrdi", rx, 8'h00);
      stop();
      program2(24'h000010, 8'hFF, 8'hEE);
`ifdef SPI_RESP_WEL_EN
      chk_mem("pp_nowren", 10'h010, 8'hA5);
`else
      chk_mem("pp_nowren", 10'h010, 8'hFF);
`endif
      single(8'h06);
      program2(24'h000020, 8'h77, 8'h88);
      single(8'h06);
      start();
      cmd_addr(8'h02, 24'h000020);
      xb(8'h99);
      shift(8'hF0, 4, rx);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_clk(3);
         sif.spi_sck = ~sif.spi_sck;
      end
      check("arst_miso", sif.spi_miso, 1'b0);
      check("arst_wel", wel, 1'b0);
      chk_mem("arst_20", 10'h020, 8'h99);
      chk_mem("arst_21", 10'h021, 8'h88);
      sif.spi_cs_n = 1'b1;
      wait_clk(4);
      rst = 1'b1;
      wait_clk(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
